// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the x0 index constant and the buffered write-entry layout
// for the register-file write-side arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of pending accelerator writes with per-entry live bits,
// kill-by-destination and CAM lookup of the two decode source indices.
module regfile_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_rd_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              head_live_o,
  output logic [ADDR_W-1:0] head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              rs1_match_o,
  output logic              rs2_match_o
);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [DEPTH-1:0]  hit1, hit2;
  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              push_ok, pop_ok;

  // Guards keep occupancy within [0, DEPTH] regardless of the caller.
  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_ok) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[tail_q]   <= push_rd_i;
      data_mem[tail_q] <= push_data_i;
    end
  end

  // Push lands in a free slot, so it never collides with the popped head;
  // a fresh push wins over a same-cycle kill because it is the newer value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_comb begin
      live_d[gi] = live_q[gi];
      if (push_ok && (tail_q == PTR_W'(gi))) begin
        live_d[gi] = 1'b1;
      end else if (pop_ok && (head_q == PTR_W'(gi))) begin
        live_d[gi] = 1'b0;
      end else if (kill_i && (rd_mem[gi] == kill_rd_i)) begin
        live_d[gi] = 1'b0;
      end
    end

    assign hit1[gi] = live_q[gi] && (rd_mem[gi] == rs1_i);
    assign hit2[gi] = live_q[gi] && (rd_mem[gi] == rs2_i);
  end

  assign rs1_match_o = (rs1_i != ADDR_W'(REG_ZERO)) && (|hit1);
  assign rs2_match_o = (rs2_i != ADDR_W'(REG_ZERO)) && (|hit2);

  assign head_live_o = live_q[head_q];
  assign head_rd_o   = rd_mem[head_q];
  assign head_data_o = data_mem[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges the pipeline WB result and the buffered accelerator results onto the
// register file's single registered write port, with starvation-driven stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int STV_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_regwrite,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ADDR_W-1:0] acc_rd,
  input  logic [DATA_W-1:0] acc_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writedata,
  output logic              regwrite,
  output logic [CNT_W-1:0]  fifo_count
);

  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;

  logic              fifo_push, fifo_pop, fifo_kill;
  logic              fifo_empty;
  logic              head_live;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  regfile_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_rd_i   (acc_rd),
    .push_data_i (acc_data),
    .pop_i       (fifo_pop),
    .kill_i      (fifo_kill),
    .kill_rd_i   (pipe_rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .head_live_o (head_live),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .rs1_match_o (rs1_pending),
    .rs2_match_o (rs2_pending)
  );

  assign fifo_empty = (fifo_count == '0);

  // Ready comes from the registered count only; a same-cycle pop never frees a slot.
  assign acc_ready  = rst_n && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push  = acc_valid && acc_ready && (acc_rd != ADDR_W'(REG_ZERO));
  assign pipe_stall = rst_n && (starve_q == STV_W'(STARVE_MAX));

  always_comb begin
    fifo_pop  = 1'b0;
    fifo_kill = 1'b0;
    we_d      = 1'b0;
    rd_d      = '0;
    wd_d      = '0;
    if (pipe_stall) begin
      fifo_pop = 1'b1;
    end else if (pipe_regwrite && (pipe_rd != ADDR_W'(REG_ZERO))) begin
      we_d      = 1'b1;
      rd_d      = pipe_rd;
      wd_d      = pipe_data;
      fifo_kill = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
    end

    // A killed head is still drained, it just produces no write.
    if (fifo_pop && head_live) begin
      we_d = 1'b1;
      rd_d = head_rd;
      wd_d = head_data;
    end
  end

  always_comb begin
    starve_d = starve_q + STV_W'(1);
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  assign rd        = rd_q;
  assign writedata = wd_q;
  assign regwrite  = we_q;

endmodule
